// File: rtl/efpga_op_arbiter.sv
// efpga_op_arbiter: shares the single eFPGA custom-instruction slot between two
// cores. Each core has a holding register. Grants are round-robin. Each
// operation gets one issue pulse and completes after a fixed delay or on the
// fabric's done signal (with a timeout). Results return to the owner with a
// one-cycle done pulse.
//
// Handshake: req_N_i is a one-cycle request pulse. It is accepted only while
// busy_N_o is low, so busy_N_o is the inverse of ready. busy_N_o rises the
// cycle after acceptance and falls on the edge that enters RESP. done_N_o is
// a one-cycle valid with no back-pressure. err_N_o and res_*_N_o are
// qualified by done_N_o.
module efpga_op_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  // core 1
  input  logic        req_1_i,
  input  logic [1:0]  operator_1_i,
  input  logic [1:0]  delay_1_i,
  input  logic [31:0] operand_a_1_i,
  input  logic [31:0] operand_b_1_i,
  output logic        busy_1_o,
  output logic        done_1_o,
  output logic        err_1_o,
  output logic [31:0] res_a_1_o,
  output logic [31:0] res_b_1_o,
  output logic [31:0] res_c_1_o,
  // core 2
  input  logic        req_2_i,
  input  logic [1:0]  operator_2_i,
  input  logic [1:0]  delay_2_i,
  input  logic [31:0] operand_a_2_i,
  input  logic [31:0] operand_b_2_i,
  output logic        busy_2_o,
  output logic        done_2_o,
  output logic        err_2_o,
  output logic [31:0] res_a_2_o,
  output logic [31:0] res_b_2_o,
  output logic [31:0] res_c_2_o,
  // fabric side
  output logic        efpga_en_o,
  output logic [1:0]  efpga_operator_o,
  output logic [1:0]  efpga_delay_o,
  output logic [31:0] efpga_operand_a_o,
  output logic [31:0] efpga_operand_b_o,
  input  logic [31:0] efpga_res_a_i,
  input  logic [31:0] efpga_res_b_i,
  input  logic [31:0] efpga_res_c_i,
  input  logic        efpga_done_i,
  output logic        grant_o,
  // debug: current FSM state encoding
  output logic [1:0]  dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // holding registers
  logic [1:0]  op_h1, dly_h1, op_h2, dly_h2;
  logic [31:0] a_h1, b_h1, a_h2, b_h2;
  logic        pend_1, pend_2, active_1, active_2;
  logic        err_q1, err_q2;
  logic        last_grant;  // 0 = core 1, 1 = core 2
  logic [CW-1:0] cnt_q;

  logic acc_1, acc_2;
  logic do_grant, grant_2, finish, tmo;
  logic fixed_dly, finish_ok, timeout_hit, pick_2, other_pend;

  assign acc_1 = req_1_i & ~busy_1_o;
  assign acc_2 = req_2_i & ~busy_2_o;

  // On a tie the core that did not own the last grant wins.
  assign pick_2     = (pend_1 & pend_2) ? ~last_grant : pend_2;
  assign other_pend = last_grant ? pend_1 : pend_2;

  assign fixed_dly   = (efpga_delay_o != 2'd0);
  assign finish_ok   = fixed_dly ? (cnt_q == (CW'(efpga_delay_o) - CW'(1))) : efpga_done_i;
  assign timeout_hit = !fixed_dly && !efpga_done_i && (cnt_q == CW'(TIMEOUT - 1));

  assign efpga_en_o  = (state_q == ISSUE);
  assign done_1_o    = (state_q == RESP) & active_1;
  assign done_2_o    = (state_q == RESP) & active_2;
  assign err_1_o     = done_1_o & err_q1;
  assign err_2_o     = done_2_o & err_q2;
  assign grant_o     = last_grant;
  assign dbg_state_o = state_q;

  // FSM state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // next-state, grant decision and completion detection
  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    grant_2  = pick_2;
    finish   = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_1 | pend_2) begin
          do_grant = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (finish_ok) begin
          finish  = 1'b1;
          state_d = RESP;
        end else if (timeout_hit) begin
          finish  = 1'b1;
          tmo     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // Hand the slot straight to a waiting core without an IDLE bubble.
        if (other_pend) begin
          do_grant = 1'b1;
          grant_2  = ~last_grant;
          state_d  = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // request acceptance into the per-core holding registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      op_h1 <= '0; dly_h1 <= '0; a_h1 <= '0; b_h1 <= '0;
      op_h2 <= '0; dly_h2 <= '0; a_h2 <= '0; b_h2 <= '0;
    end else begin
      if (acc_1) begin
        op_h1 <= operator_1_i; dly_h1 <= delay_1_i;
        a_h1  <= operand_a_1_i; b_h1  <= operand_b_1_i;
      end
      if (acc_2) begin
        op_h2 <= operator_2_i; dly_h2 <= delay_2_i;
        a_h2  <= operand_a_2_i; b_h2  <= operand_b_2_i;
      end
    end
  end

  // pend / active / busy bookkeeping per core
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pend_1   <= 1'b0; pend_2   <= 1'b0;
      active_1 <= 1'b0; active_2 <= 1'b0;
      busy_1_o <= 1'b0; busy_2_o <= 1'b0;
    end else begin
      pend_1 <= acc_1 | (pend_1 & ~(do_grant & ~grant_2));
      pend_2 <= acc_2 | (pend_2 & ~(do_grant &  grant_2));

      if (do_grant & ~grant_2)  active_1 <= 1'b1;
      else if (state_q == RESP) active_1 <= 1'b0;
      if (do_grant & grant_2)   active_2 <= 1'b1;
      else if (state_q == RESP) active_2 <= 1'b0;

      // busy falls on the edge entering RESP so the owner may re-request there
      if (acc_1)                    busy_1_o <= 1'b1;
      else if (finish & active_1)   busy_1_o <= 1'b0;
      if (acc_2)                    busy_2_o <= 1'b1;
      else if (finish & active_2)   busy_2_o <= 1'b0;
    end
  end

  // grant owner and registered fabric request outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      last_grant        <= 1'b1;
      efpga_operator_o  <= '0;
      efpga_delay_o     <= '0;
      efpga_operand_a_o <= '0;
      efpga_operand_b_o <= '0;
    end else if (do_grant) begin
      last_grant        <= grant_2;
      efpga_operator_o  <= grant_2 ? op_h2  : op_h1;
      efpga_delay_o     <= grant_2 ? dly_h2 : dly_h1;
      efpga_operand_a_o <= grant_2 ? a_h2   : a_h1;
      efpga_operand_b_o <= grant_2 ? b_h2   : b_h1;
    end
  end

  // WAIT cycle counter, cleared while issuing
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)              cnt_q <= '0;
    else if (state_q == ISSUE)   cnt_q <= '0;
    else if (state_q == WAIT)    cnt_q <= cnt_q + CW'(1);
  end

  // result capture into the owner's result registers; a timeout clears them
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      res_a_1_o <= '0; res_b_1_o <= '0; res_c_1_o <= '0; err_q1 <= 1'b0;
      res_a_2_o <= '0; res_b_2_o <= '0; res_c_2_o <= '0; err_q2 <= 1'b0;
    end else if (finish) begin
      if (active_1) begin
        res_a_1_o <= tmo ? '0 : efpga_res_a_i;
        res_b_1_o <= tmo ? '0 : efpga_res_b_i;
        res_c_1_o <= tmo ? '0 : efpga_res_c_i;
        err_q1    <= tmo;
      end
      if (active_2) begin
        res_a_2_o <= tmo ? '0 : efpga_res_a_i;
        res_b_2_o <= tmo ? '0 : efpga_res_b_i;
        res_c_2_o <= tmo ? '0 : efpga_res_c_i;
        err_q2    <= tmo;
      end
    end
  end

endmodule

// File: tb/tb_efpga_op_arbiter.sv
// Testbench for efpga_op_arbiter: directed stimulus with hand-computed
// expectations pushed into issue and completion queues, a monitor that pops
// and compares on every efpga_en_o and done pulse, and a small fabric model.
module tb_efpga_op_arbiter;

  localparam int IW = 101;  // {cycle, grant, op, delay, a, b}
  localparam int DW = 130;  // {cycle, core, err, res_a, res_b, res_c}

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b1;
  logic        req_1_i = 0, req_2_i = 0;
  logic [1:0]  operator_1_i = 0, delay_1_i = 0, operator_2_i = 0, delay_2_i = 0;
  logic [31:0] operand_a_1_i = 0, operand_b_1_i = 0, operand_a_2_i = 0, operand_b_2_i = 0;
  logic        busy_1_o, done_1_o, err_1_o, busy_2_o, done_2_o, err_2_o;
  logic [31:0] res_a_1_o, res_b_1_o, res_c_1_o, res_a_2_o, res_b_2_o, res_c_2_o;
  logic        efpga_en_o, grant_o;
  logic [1:0]  efpga_operator_o, efpga_delay_o, dbg_state_o;
  logic [31:0] efpga_operand_a_o, efpga_operand_b_o;
  logic [31:0] efpga_res_a_i, efpga_res_b_i, efpga_res_c_i;
  logic        efpga_done_i = 1'b0;

  // fabric model controls
  logic        fab_mode = 1'b0;  // 0: constant results, 1: computed from operands
  logic [31:0] fab_ra = 0, fab_rb = 0, fab_rc = 0;
  int          fab_lat = 0;      // cycles from en to done pulse, 0 = never
  int          fab_cnt = 0;

  int unsigned cyc = 0;
  int          errors = 0, checks = 0;
  logic        seen_aa = 1'b0;
  logic [IW-1:0] iss_q[$];
  logic [DW-1:0] exp_q[$];

  assign efpga_res_a_i = fab_mode ? efpga_operand_a_o + efpga_operand_b_o : fab_ra;
  assign efpga_res_b_i = fab_mode ? efpga_operand_a_o ^ efpga_operand_b_o : fab_rb;
  assign efpga_res_c_i = fab_mode ? {30'd0, efpga_operator_o} : fab_rc;

  efpga_op_arbiter #(.TIMEOUT(256)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .req_1_i(req_1_i), .operator_1_i(operator_1_i), .delay_1_i(delay_1_i),
    .operand_a_1_i(operand_a_1_i), .operand_b_1_i(operand_b_1_i),
    .busy_1_o(busy_1_o), .done_1_o(done_1_o), .err_1_o(err_1_o),
    .res_a_1_o(res_a_1_o), .res_b_1_o(res_b_1_o), .res_c_1_o(res_c_1_o),
    .req_2_i(req_2_i), .operator_2_i(operator_2_i), .delay_2_i(delay_2_i),
    .operand_a_2_i(operand_a_2_i), .operand_b_2_i(operand_b_2_i),
    .busy_2_o(busy_2_o), .done_2_o(done_2_o), .err_2_o(err_2_o),
    .res_a_2_o(res_a_2_o), .res_b_2_o(res_b_2_o), .res_c_2_o(res_c_2_o),
    .efpga_en_o(efpga_en_o), .efpga_operator_o(efpga_operator_o),
    .efpga_delay_o(efpga_delay_o), .efpga_operand_a_o(efpga_operand_a_o),
    .efpga_operand_b_o(efpga_operand_b_o),
    .efpga_res_a_i(efpga_res_a_i), .efpga_res_b_i(efpga_res_b_i),
    .efpga_res_c_i(efpga_res_c_i), .efpga_done_i(efpga_done_i),
    .grant_o(grant_o), .dbg_state_o(dbg_state_o)
  );

  // clock and cycle counter
  initial forever #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_iss(input int unsigned c, input logic g, input logic [1:0] op,
                                   input logic [1:0] dly, input logic [31:0] a, input logic [31:0] b);
    iss_q.push_back({c, g, op, dly, a, b});
  endfunction

  function automatic void push_done(input int unsigned c, input logic core, input logic err,
                                    input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] rc);
    exp_q.push_back({c, core, err, ra, rb, rc});
  endfunction

  // driver tasks
  task automatic req(input int core, input logic [1:0] op, input logic [1:0] dly,
                     input logic [31:0] a, input logic [31:0] b);
    if (core == 1) begin
      req_1_i = 1; operator_1_i = op; delay_1_i = dly; operand_a_1_i = a; operand_b_1_i = b;
    end else begin
      req_2_i = 1; operator_2_i = op; delay_2_i = dly; operand_a_2_i = a; operand_b_2_i = b;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge wb_clk_i); #1;
      req_1_i = 0; req_2_i = 0;
    end
  endtask

  // fabric: raises efpga_done_i for one cycle fab_lat cycles after each en
  initial forever begin
    @(posedge wb_clk_i); #1;
    efpga_done_i = 1'b0;
    if (fab_cnt != 0) begin
      fab_cnt--;
      if (fab_cnt == 0) efpga_done_i = 1'b1;
    end
    if (efpga_en_o && fab_lat != 0) fab_cnt = fab_lat;
  end

  // monitor: pops and compares whenever the DUT issues or completes
  initial begin
    logic [IW-1:0] ie;
    logic [DW-1:0] de;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_ni) begin
        if (efpga_operand_a_o == 32'hAA) seen_aa = 1'b1;
        if (efpga_en_o) begin
          if (iss_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_issue: got en with op_a %0h expected none (cycle %0d)",
                     efpga_operand_a_o, cyc);
          end else begin
            ie = iss_q.pop_front();
            chk("issue", {cyc, grant_o, efpga_operator_o, efpga_delay_o,
                          efpga_operand_a_o, efpga_operand_b_o}, ie);
          end
        end
        if (done_1_o && done_2_o) begin
          checks++; errors++;
          $display("FAIL double_done: got both done pulses expected one (cycle %0d)", cyc);
        end else if (done_1_o || done_2_o) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done core2=%0d expected none (cycle %0d)",
                     done_2_o, cyc);
          end else begin
            de = exp_q.pop_front();
            if (done_2_o)
              chk("done", {cyc, 1'b1, err_2_o, res_a_2_o, res_b_2_o, res_c_2_o}, de);
            else
              chk("done", {cyc, 1'b0, err_1_o, res_a_1_o, res_b_1_o, res_c_1_o}, de);
          end
        end
      end
    end
  end

  // directed stimulus
  initial begin
    int unsigned t0;

    // reset state
    #1 wb_rst_ni = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("reset_flags", {busy_1_o, busy_2_o, done_1_o, done_2_o, err_1_o, err_2_o,
                        efpga_en_o, grant_o, dbg_state_o}, 10'b0000000100);
    chk("reset_res", {res_a_1_o, res_b_1_o, res_c_1_o, res_a_2_o, res_b_2_o}, 160'd0);
    chk("reset_fabric_out", {res_c_2_o, efpga_operator_o, efpga_delay_o,
                             efpga_operand_a_o, efpga_operand_b_o}, 100'd0);
    wb_rst_ni = 1'b1;
    step(2);

    // tie, D=0, fabric done 3 cycles after en; core 1 first, no bubble before core 2
    fab_mode = 1'b1; fab_lat = 3;
    t0 = cyc;
    req(1, 2'd1, 2'd0, 32'h0F, 32'h01);
    req(2, 2'd3, 2'd0, 32'h20, 32'h22);
    push_iss(t0 + 2, 1'b0, 2'd1, 2'd0, 32'h0F, 32'h01);
    push_done(t0 + 6, 1'b0, 1'b0, 32'h10, 32'h0E, 32'h1);
    push_iss(t0 + 7, 1'b1, 2'd3, 2'd0, 32'h20, 32'h22);
    push_done(t0 + 11, 1'b1, 1'b0, 32'h42, 32'h02, 32'h3);
    step(16);

    // fixed delay D=2
    fab_mode = 1'b0; fab_lat = 0;
    fab_ra = 32'h12; fab_rb = 32'h34; fab_rc = 32'h56;
    t0 = cyc;
    req(1, 2'd2, 2'd2, 32'd5, 32'd7);
    push_iss(t0 + 2, 1'b0, 2'd2, 2'd2, 32'd5, 32'd7);
    push_done(t0 + 5, 1'b0, 1'b0, 32'h12, 32'h34, 32'h56);
    step(1);
    chk("busy1_after_req", busy_1_o, 1'b1);
    step(8);

    // requests while busy are ignored
    fab_ra = 32'hA1; fab_rb = 32'hB2; fab_rc = 32'hC3;
    t0 = cyc;
    req(2, 2'd1, 2'd2, 32'h55, 32'h66);
    push_iss(t0 + 2, 1'b1, 2'd1, 2'd2, 32'h55, 32'h66);
    push_done(t0 + 5, 1'b1, 1'b0, 32'hA1, 32'hB2, 32'hC3);
    step(1);
    chk("busy2_set", busy_2_o, 1'b1);
    req(2, 2'd3, 2'd1, 32'hAA, 32'hAA);
    step(2);
    req(2, 2'd3, 2'd1, 32'hAA, 32'hAA);
    step(2);
    chk("busy2_low_in_resp", {done_2_o, busy_2_o}, 2'b10);
    step(6);

    // round-robin: each core re-requests during its own RESP
    t0 = cyc;
    req(1, 2'd0, 2'd1, 32'h1, 32'h2);
    req(2, 2'd2, 2'd1, 32'h11, 32'h12);
    push_iss(t0 + 2,  1'b0, 2'd0, 2'd1, 32'h1,  32'h2);
    push_done(t0 + 4, 1'b0, 1'b0, 32'hA1, 32'hB2, 32'hC3);
    push_iss(t0 + 5,  1'b1, 2'd2, 2'd1, 32'h11, 32'h12);
    push_done(t0 + 7, 1'b1, 1'b0, 32'hA1, 32'hB2, 32'hC3);
    push_iss(t0 + 8,  1'b0, 2'd1, 2'd1, 32'h3,  32'h4);
    push_done(t0 + 10, 1'b0, 1'b0, 32'hA1, 32'hB2, 32'hC3);
    push_iss(t0 + 11, 1'b1, 2'd3, 2'd1, 32'h13, 32'h14);
    push_done(t0 + 13, 1'b1, 1'b0, 32'hA1, 32'hB2, 32'hC3);
    step(4);
    req(1, 2'd1, 2'd1, 32'h3, 32'h4);
    step(3);
    req(2, 2'd3, 2'd1, 32'h13, 32'h14);
    step(12);

    // timeout: D=0 and the fabric never answers
    fab_ra = 32'hDEAD; fab_rb = 32'hBEEF; fab_rc = 32'hCAFE;
    t0 = cyc;
    req(1, 2'd0, 2'd0, 32'h9, 32'h9);
    push_iss(t0 + 2, 1'b0, 2'd0, 2'd0, 32'h9, 32'h9);
    push_done(t0 + 259, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
    step(265);

    // reset mid-WAIT with core 2 pending
    t0 = cyc;
    req(1, 2'd1, 2'd0, 32'h33, 32'h44);
    push_iss(t0 + 2, 1'b0, 2'd1, 2'd0, 32'h33, 32'h44);
    step(3);
    req(2, 2'd2, 2'd1, 32'h77, 32'h88);
    step(2);
    chk("busy_before_abort", {busy_1_o, busy_2_o, dbg_state_o}, 4'b1110);
    wb_rst_ni = 1'b0;
    #1;
    chk("abort_flags", {busy_1_o, busy_2_o, done_1_o, done_2_o, err_1_o, err_2_o,
                        efpga_en_o, grant_o, dbg_state_o}, 10'b0000000100);
    chk("abort_res", {res_a_1_o, res_b_1_o, res_c_1_o, res_a_2_o, res_b_2_o}, 160'd0);
    chk("abort_fabric_out", {res_c_2_o, efpga_operator_o, efpga_delay_o,
                             efpga_operand_a_o, efpga_operand_b_o}, 100'd0);
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_ni = 1'b1;
    step(20);
    chk("no_pend_after_abort", {busy_1_o, busy_2_o, dbg_state_o}, 4'b0000);

    // final report
    chk("issue_queue_drained", iss_q.size(), 0);
    chk("done_queue_drained", exp_q.size(), 0);
    chk("ignored_operand_never_issued", seen_aa, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
